nnet_mac_axil: RTL and testbench

AXI4-Lite slave multiply-accumulate unit for the neural-net datapath. It sits directly downstream of the AXI4-Lite master (PS or verification VIP) on the `S00_AXI` port, in the slot the 4-register lab IP occupies today. It exposes four 32-bit registers. Each write to INPUT performs one signed 16x16 multiply of WEIGHT by INPUT and adds the product into a saturating 32-bit accumulator that software reads back.

---
 rtl/nnet_mac_axil_if.sv | 42 ++++
 rtl/nnet_mac_axil.sv | 165 ++++++++++++++++
 tb/tb_nnet_mac_axil.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/nnet_mac_axil_if.sv
// AXI4-Lite bundle for the S00_AXI port of the MAC unit.
// The master modport drives requests, the slave modport answers them.
interface nnet_mac_axil_if #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]     awaddr;
    logic [2:0]                        awprot;
    logic                              awvalid;
    logic                              awready;
    logic [C_S_AXI_DATA_WIDTH-1:0]     wdata;
    logic [C_S_AXI_DATA_WIDTH/8-1:0]   wstrb;
    logic                              wvalid;
    logic                              wready;
    logic [1:0]                        bresp;
    logic                              bvalid;
    logic                              bready;
    logic [C_S_AXI_ADDR_WIDTH-1:0]     araddr;
    logic [2:0]                        arprot;
    logic                              arvalid;
    logic                              arready;
    logic [C_S_AXI_DATA_WIDTH-1:0]     rdata;
    logic [1:0]                        rresp;
    logic                              rvalid;
    logic                              rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/nnet_mac_axil.sv
// AXI4-Lite slave with a two-stage signed 16x16 multiply-accumulate and a saturating 32-bit ACC.
// Register map: WEIGHT, INPUT (starts a MAC), ACC (write clears), CTRL/STATUS.
module nnet_mac_axil #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic           s00_axi_aclk,
    input  logic           s00_axi_aresetn,
    nnet_mac_axil_if.slave s00_axi
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int AW = C_S_AXI_ADDR_WIDTH;

    typedef enum logic [1:0] {WR_IDLE, WR_ACK, WR_RESP} wrState_e;
    typedef enum logic [1:0] {RD_IDLE, RD_ACK, RD_DATA} rdState_e;

    wrState_e wrState_q, wrState_d;
    rdState_e rdState_q, rdState_d;

    logic [DW-1:0] weight_q, input_q, acc_q, rdata_q;
    logic [15:0]   cnt_q;
    logic          ovf_q;
    logic          stage1Valid_q, stage2Valid_q;
    logic [31:0]   product_q;

    logic          busy, wrFire, rdFire, ovfHit;
    logic [1:0]    wrIdx, rdIdx;
    logic [DW-1:0] wrMerged, rdMux, accSat_d;
    logic [32:0]   sum;
    logic          unusedBits;

    function automatic logic [DW-1:0] applyStrobe(input logic [DW-1:0] oldVal,
                                                  input logic [DW-1:0] newVal,
                                                  input logic [DW/8-1:0] strb);
        logic [DW-1:0] res;
        res = oldVal;
        for (int b = 0; b < DW/8; b++) begin
            if (strb[b]) res[8*b +: 8] = newVal[8*b +: 8];
        end
        return res;
    endfunction

    assign wrIdx      = s00_axi.awaddr[AW-1 -: 2];
    assign rdIdx      = s00_axi.araddr[AW-1 -: 2];
    assign busy       = stage1Valid_q | stage2Valid_q;
    assign wrFire     = (wrState_q == WR_ACK) && s00_axi.awvalid && s00_axi.wvalid;
    assign rdFire     = (rdState_q == RD_ACK) && s00_axi.arvalid;
    assign unusedBits = ^{s00_axi.awprot, s00_axi.arprot, s00_axi.awaddr[AW-3:0], s00_axi.araddr[AW-3:0]};

    always_comb begin
        wrMerged = applyStrobe((wrIdx == 2'd0) ? weight_q : input_q, s00_axi.wdata, s00_axi.wstrb);
    end

    // Both operands sign-extend to 33 bits; disagreement of the top two sum bits means overflow.
    always_comb begin
        sum      = {acc_q[31], acc_q} + {product_q[31], product_q};
        ovfHit   = sum[32] != sum[31];
        accSat_d = sum[31:0];
        if (ovfHit) accSat_d = sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end

    always_comb begin
        rdMux = '0;
        case (rdIdx)
            2'd0:    rdMux = weight_q;
            2'd1:    rdMux = input_q;
            2'd2:    rdMux = acc_q;
            default: rdMux = {cnt_q, 13'b0, 1'b0, ovf_q, busy};
        endcase
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            wrState_q <= WR_IDLE;
            rdState_q <= RD_IDLE;
        end else begin
            wrState_q <= wrState_d;
            rdState_q <= rdState_d;
        end
    end

    // Acceptance waits for both AW and W and for the MAC pipeline to drain.
    always_comb begin
        wrState_d       = wrState_q;
        s00_axi.awready = 1'b0;
        s00_axi.wready  = 1'b0;
        s00_axi.bvalid  = 1'b0;
        s00_axi.bresp   = 2'b00;
        case (wrState_q)
            WR_IDLE: begin
                if (s00_axi.awvalid && s00_axi.wvalid && !busy) wrState_d = WR_ACK;
            end
            WR_ACK: begin
                s00_axi.awready = 1'b1;
                s00_axi.wready  = 1'b1;
                wrState_d = wrFire ? WR_RESP : WR_IDLE;
            end
            WR_RESP: begin
                s00_axi.bvalid = 1'b1;
                if (s00_axi.bready) wrState_d = WR_IDLE;
            end
            default: wrState_d = WR_IDLE;
        endcase
    end

    always_comb begin
        rdState_d       = rdState_q;
        s00_axi.arready = 1'b0;
        s00_axi.rvalid  = 1'b0;
        s00_axi.rresp   = 2'b00;
        s00_axi.rdata   = rdata_q;
        case (rdState_q)
            RD_IDLE: begin
                if (s00_axi.arvalid && !busy) rdState_d = RD_ACK;
            end
            RD_ACK: begin
                s00_axi.arready = 1'b1;
                rdState_d = rdFire ? RD_DATA : RD_IDLE;
            end
            RD_DATA: begin
                s00_axi.rvalid = 1'b1;
                if (s00_axi.rready) rdState_d = RD_IDLE;
            end
            default: rdState_d = RD_IDLE;
        endcase
    end

    // stage1Valid_q marks operands captured in WEIGHT/INPUT; stage2Valid_q marks product_q ready to add.
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            weight_q      <= '0;
            input_q       <= '0;
            acc_q         <= '0;
            cnt_q         <= '0;
            ovf_q         <= 1'b0;
            stage1Valid_q <= 1'b0;
            stage2Valid_q <= 1'b0;
            product_q     <= '0;
            rdata_q       <= '0;
        end else begin
            stage1Valid_q <= wrFire && (wrIdx == 2'd1);
            stage2Valid_q <= stage1Valid_q;
            if (stage1Valid_q) begin
                product_q <= 32'($signed(weight_q[15:0])) * 32'($signed(input_q[15:0]));
            end
            if (stage2Valid_q) begin
                acc_q <= accSat_d;
                cnt_q <= cnt_q + 16'd1;
                if (ovfHit) ovf_q <= 1'b1;
            end
            if (wrFire) begin
                case (wrIdx)
                    2'd0: weight_q <= wrMerged;
                    2'd1: input_q  <= wrMerged;
                    2'd2: acc_q    <= '0;
                    default: begin
                        if (s00_axi.wdata[1]) ovf_q <= 1'b0;
                        if (s00_axi.wdata[2]) cnt_q <= '0;
                    end
                endcase
            end
            if (rdFire) rdata_q <= rdMux;
        end
    end
endmodule

// File: tb/tb_nnet_mac_axil.sv
// Self-checking bench for nnet_mac_axil: reference model of the register file and MAC,
// read expectations queued at issue and compared when RVALID arrives.
module tb_nnet_mac_axil;
    localparam longint ACC_MAX = 64'sd2147483647;
    localparam longint ACC_MIN = -64'sd2147483648;
    localparam int     BOUND   = 50;

    logic clk;
    logic aresetn;
    int   assertCount = 0;
    int   failCount   = 0;

    logic [31:0] expQ[$];
    string       tagQ[$];

    logic [31:0] mWeight, mInput, mAcc;
    logic [15:0] mCnt;
    logic        mOvf;

    nnet_mac_axil_if bus();

    nnet_mac_axil dut (
        .s00_axi_aclk   (clk),
        .s00_axi_aresetn(aresetn),
        .s00_axi        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] mergeBytes(input logic [31:0] oldVal, input logic [31:0] newVal,
                                               input logic [3:0] strb);
        logic [31:0] res;
        res = oldVal;
        for (int b = 0; b < 4; b++) if (strb[b]) res[8*b +: 8] = newVal[8*b +: 8];
        return res;
    endfunction

    function automatic void modelReset();
        mWeight = '0; mInput = '0; mAcc = '0; mCnt = '0; mOvf = 1'b0;
    endfunction

    function automatic void modelMac();
        longint p, s;
        p = longint'($signed(mWeight[15:0])) * longint'($signed(mInput[15:0]));
        s = longint'($signed(mAcc)) + p;
        if (s > ACC_MAX) begin
            mAcc = 32'h7FFF_FFFF; mOvf = 1'b1;
        end else if (s < ACC_MIN) begin
            mAcc = 32'h8000_0000; mOvf = 1'b1;
        end else begin
            mAcc = s[31:0];
        end
        mCnt = mCnt + 16'd1;
    endfunction

    function automatic void modelWrite(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        case (addr[3:2])
            2'd0: mWeight = mergeBytes(mWeight, data, strb);
            2'd1: begin mInput = mergeBytes(mInput, data, strb); modelMac(); end
            2'd2: mAcc = '0;
            default: begin
                if (data[1]) mOvf = 1'b0;
                if (data[2]) mCnt = '0;
            end
        endcase
    endfunction

    function automatic logic [31:0] modelReg(input logic [3:0] addr);
        case (addr[3:2])
            2'd0:    return mWeight;
            2'd1:    return mInput;
            2'd2:    return mAcc;
            default: return {mCnt, 13'b0, 1'b0, mOvf, 1'b0};
        endcase
    endfunction

    // Drive W wLead cycles ahead of AW, then hold BREADY low for bHold cycles once BVALID shows.
    task automatic applyStimulus(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                                 input int wLead, input int bHold);
        int n;
        bus.wdata  = data;
        bus.wstrb  = strb;
        bus.wvalid = 1'b1;
        bus.bready = (bHold == 0);
        for (int i = 0; i < wLead; i++) begin
            @(posedge clk); #1;
            checkOutput("wLeadReady", {31'b0, bus.wready}, 32'd0);
        end
        bus.awaddr  = addr;
        bus.awvalid = 1'b1;
        n = 0;
        while (!(bus.awready && bus.wready) && n < BOUND) begin
            @(posedge clk); #1; n++;
        end
        checkOutput("wrAccept", {31'b0, bus.awready & bus.wready}, 32'd1);
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        modelWrite(addr, data, strb);
        n = 0;
        while (!bus.bvalid && n < BOUND) begin
            @(posedge clk); #1; n++;
        end
        checkOutput("bvalid", {31'b0, bus.bvalid}, 32'd1);
        for (int i = 0; i < bHold; i++) begin
            @(posedge clk); #1;
            checkOutput("bHoldValid", {31'b0, bus.bvalid}, 32'd1);
            checkOutput("bHoldResp", {30'b0, bus.bresp}, 32'd0);
        end
        checkOutput("bresp", {30'b0, bus.bresp}, 32'd0);
        bus.bready = 1'b1;
        @(posedge clk); #1;
        checkOutput("bSingle", {31'b0, bus.bvalid}, 32'd0);
    endtask

    // Completes a read whose ARVALID is already up and whose expectation is already queued.
    task automatic finishRead();
        int n;
        logic [31:0] exp;
        string tag;
        n = 0;
        while (!bus.arready && n < BOUND) begin
            @(posedge clk); #1; n++;
        end
        checkOutput("arready", {31'b0, bus.arready}, 32'd1);
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        n = 0;
        while (!bus.rvalid && n < BOUND) begin
            @(posedge clk); #1; n++;
        end
        checkOutput("rvalid", {31'b0, bus.rvalid}, 32'd1);
        exp = expQ.pop_front();
        tag = tagQ.pop_front();
        checkOutput(tag, bus.rdata, exp);
        checkOutput("rresp", {30'b0, bus.rresp}, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic axiRead(input logic [3:0] addr, input logic [31:0] expected, input string tag);
        expQ.push_back(expected);
        tagQ.push_back(tag);
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        finishRead();
    endtask

    initial begin
        int n;
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata  = '0; bus.wstrb  = '0; bus.wvalid  = 1'b0;
        bus.bready = 1'b1;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b1;
        modelReset();
        aresetn = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("rstAwready", {31'b0, bus.awready}, 32'd0);
        checkOutput("rstWready",  {31'b0, bus.wready},  32'd0);
        checkOutput("rstBvalid",  {31'b0, bus.bvalid},  32'd0);
        checkOutput("rstArready", {31'b0, bus.arready}, 32'd0);
        checkOutput("rstRvalid",  {31'b0, bus.rvalid},  32'd0);
        checkOutput("rstRdata",   bus.rdata, 32'd0);
        aresetn = 1'b1;
        @(posedge clk); #1;

        for (int a = 0; a < 4; a++) axiRead(4'(a * 4), 32'h0, "rstReg");

        applyStimulus(4'h0, 32'h0000_0003, 4'hF, 0, 0);
        applyStimulus(4'h4, 32'h0000_0004, 4'hF, 0, 0);
        applyStimulus(4'h4, 32'hFFFF_FFFE, 4'hF, 0, 0);
        axiRead(4'h8, 32'h0000_0006, "accBasic");
        axiRead(4'hC, 32'h0002_0000, "ctrlBasic");
        axiRead(4'h4, 32'hFFFF_FFFE, "inputReg");

        applyStimulus(4'h8, 32'h0, 4'hF, 0, 0);
        applyStimulus(4'hC, 32'h4, 4'hF, 0, 0);
        axiRead(4'hC, 32'h0, "ctrlCleared");
        applyStimulus(4'h0, 32'h0000_7FFF, 4'hF, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(4'h4, 32'h0000_7FFF, 4'hF, 0, 0);
        axiRead(4'h8, 32'h7FFF_FFFF, "accPosSat");
        axiRead(4'hC, 32'h0003_0002, "ctrlPosSat");
        applyStimulus(4'hC, 32'h2, 4'hF, 0, 0);
        axiRead(4'hC, 32'h0003_0000, "ctrlOvfClr");

        applyStimulus(4'h8, 32'hDEAD_BEEF, 4'h0, 0, 0);
        axiRead(4'h8, 32'h0, "accClrNoStrb");
        applyStimulus(4'h0, 32'h0000_8000, 4'hF, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(4'h4, 32'h0000_7FFF, 4'hF, 0, 0);
        axiRead(4'h8, 32'h8000_0000, "accNegSat");
        axiRead(4'hC, 32'h0006_0002, "ctrlNegSat");

        applyStimulus(4'h0, 32'h1234_5678, 4'b0011, 0, 0);
        axiRead(4'h0, 32'h0000_5678, "weightStrb");
        applyStimulus(4'h0, 32'h0000_0002, 4'hF, 3, 0);
        axiRead(4'h0, modelReg(4'h0), "weightWFirst");
        applyStimulus(4'h0, 32'h0000_FFFD, 4'hF, 0, 5);
        axiRead(4'h0, 32'h0000_FFFD, "weightBHold");

        // INPUT write with a read of ACC queued right behind it: the read must wait out the MAC.
        applyStimulus(4'h8, 32'h0, 4'hF, 0, 0);
        applyStimulus(4'hC, 32'h6, 4'hF, 0, 0);
        bus.awaddr = 4'h4; bus.wdata = 32'h0000_0005; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        n = 0;
        while (!(bus.awready && bus.wready) && n < BOUND) begin
            @(posedge clk); #1; n++;
        end
        checkOutput("stallWrAccept", {31'b0, bus.awready}, 32'd1);
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        modelWrite(4'h4, 32'h0000_0005, 4'hF);
        expQ.push_back(32'hFFFF_FFF1);
        tagQ.push_back("accAfterStall");
        bus.araddr = 4'h8; bus.arvalid = 1'b1;
        checkOutput("stallArready1", {31'b0, bus.arready}, 32'd0);
        @(posedge clk); #1;
        checkOutput("stallArready2", {31'b0, bus.arready}, 32'd0);
        finishRead();
        axiRead(4'hC, 32'h0001_0000, "ctrlAfterStall");

        for (int i = 0; i < 6; i++) begin
            applyStimulus(4'h0, $urandom, 4'hF, 0, 0);
            applyStimulus(4'h4, $urandom, 4'($urandom_range(0, 15)), 0, 0);
            axiRead(4'h8, modelReg(4'h8), "accRandom");
            axiRead(4'hC, modelReg(4'hC), "ctrlRandom");
        end

        // Reset lands one cycle after an INPUT handshake; the in-flight MAC must vanish.
        applyStimulus(4'h0, 32'h0000_0100, 4'hF, 0, 0);
        bus.awaddr = 4'h4; bus.wdata = 32'h0000_0100; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        n = 0;
        while (!(bus.awready && bus.wready) && n < BOUND) begin
            @(posedge clk); #1; n++;
        end
        checkOutput("midMacAccept", {31'b0, bus.awready}, 32'd1);
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        aresetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        aresetn = 1'b1;
        modelReset();
        @(posedge clk); #1;
        checkOutput("midMacBvalid", {31'b0, bus.bvalid}, 32'd0);
        axiRead(4'h8, 32'h0, "accMidReset");
        axiRead(4'hC, 32'h0, "ctrlMidReset");
        axiRead(4'h0, 32'h0, "weightMidReset");

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
